dd_clk_gate_ctrl: RTL and testbench
===================================

// Module: dd_clk_gate_ctrl
// PURPOSE
//   Data-driven clock-gating controller. Sits directly upstream of the gated
//   register stage (test4bit-style D_IN/CLK/EN/D_OUT register) and drives its
//   D_IN and EN. EN is asserted only when the incoming sample differs from the
//   last forwarded value. A hysteresis FSM keeps EN high briefly after activity
//   stops, to limit toggling of the ICG enable.
// PARAMETERS
//   WIDTH        4   data width, must match the downstream register
//   HOLD_CYCLES  2   cycles EN stays high after the last change (0 = none)
//   CNT_W        8   width of the saturating suppressed-sample counter
// PORTS
//   CLK        in   1      single clock; rising edge
//   RST        in   1      asynchronous, active-high reset
//   D_IN       in   WIDTH  upstream sample
//   VALID      in   1      D_IN carries a new sample this cycle
//   FORCE_EN   in   1      test/scan override: forces EN high
//   D_OUT      out  WIDTH  registered data to downstream D_IN (also the shadow copy)
//   EN         out  1      registered enable to downstream EN
//   STATE      out  2      FSM state: 0=IDLE 1=ACTIVE 2=HOLD
//   GATED_CNT  out  CNT_W  saturating count of suppressed samples
// BEHAVIOUR
//   - Reset (async, active-high): D_OUT=0, EN=0, STATE=IDLE, hold counter=0,
//     GATED_CNT=0. All are cleared immediately on RST, without waiting for CLK.
//     The first edge after RST falls is evaluated from IDLE.
//   - chg = VALID && (D_IN != D_OUT). All outputs are registered (1-cycle latency).
//     The downstream register captures D_OUT on the following edge.
//   - On an edge with chg=1: D_OUT <= D_IN. Otherwise D_OUT holds.
//   - FSM transitions (evaluated on the rising edge of CLK):
//       IDLE   : chg -> ACTIVE; else stay in IDLE.
//       ACTIVE : chg -> stay in ACTIVE.
//                !chg and HOLD_CYCLES>0 -> HOLD, load hcnt=HOLD_CYCLES-1.
//                !chg and HOLD_CYCLES==0 -> IDLE.
//       HOLD   : chg -> ACTIVE and clear hcnt.
//                else if hcnt==0 -> IDLE.
//                else hcnt <= hcnt-1.
//     HOLD therefore lasts exactly HOLD_CYCLES cycles without a change.
//     VALID=0 counts as "no change".
//   - EN <= (next_state != IDLE) || FORCE_EN.
//     FORCE_EN does not affect the FSM or D_OUT.
//   - GATED_CNT increments on each edge where VALID=1, chg=0 and next EN=0.
//     It saturates at 2^CNT_W-1 and never wraps.
//   - Simultaneous chg and hold-count expiry: chg wins and the FSM goes to ACTIVE.
//   - D_IN is sampled only when VALID=1. X on D_IN while VALID=0 must not
//     propagate to any output.
// TESTING  (WIDTH=4, HOLD_CYCLES=2, CNT_W=4 unless noted)
//   1. Pulse RST between clock edges during ACTIVE -> D_OUT=0, EN=0, STATE=0,
//      GATED_CNT=0 immediately (before the next edge).
//   2. From reset, VALID=1 D_IN=4'd1 for one edge -> D_OUT=1, EN=1, STATE=1.
//      On the following edge the downstream register holds 1.
//   3. Continue with VALID=1 D_IN=1 for 4 more edges -> EN=1,1,0,0;
//      STATE=2,2,0,0; GATED_CNT=2.
//   4. In HOLD (after 1 repeat), apply D_IN=4'd13 -> D_OUT=13, EN=1, STATE=1.
//      Then 2 idle edges -> HOLD, then IDLE on the 3rd.
//   5. In IDLE, FORCE_EN=1 with VALID=1 D_IN=D_OUT -> EN=1, STATE=0,
//      GATED_CNT unchanged. Drop FORCE_EN -> EN=0 on the next edge.
//   6. In IDLE, 20 edges of VALID=1 with D_IN unchanged -> GATED_CNT=15
//      (saturated). Then D_IN=4'd15 -> D_OUT=15, EN=1, GATED_CNT stays 15.

Source files
------------

// File: rtl/dd_clk_gate_ctrl.sv
// Data-driven clock-gate controller: forwards changed samples and raises EN only around activity.
// Latency: 1 cycle from D_IN/VALID/FORCE_EN to D_OUT/EN/STATE/GATED_CNT (all registered).
// Backpressure: none; a sample is accepted on every edge where VALID=1, and repeats are counted as gated.
module dd_clk_gate_ctrl #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             VALID,
  input  logic             FORCE_EN,
  output logic [WIDTH-1:0] D_OUT,
  output logic             EN,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] GATED_CNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Hold counter only ever holds values up to HOLD_CYCLES-1.
  localparam int HCNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? HCNT_W'(HOLD_CYCLES - 1) : '0;

  state_t            state;
  state_t            state_nxt;
  logic [HCNT_W-1:0] hcnt;
  logic [HCNT_W-1:0] hcnt_nxt;
  logic              chg;
  logic              en_nxt;
  logic              gate_inc;

  // Change detect, hysteresis next-state, enable and gated-sample qualifier.
  always_comb begin
    // VALID gates the compare so an X on D_IN while idle never reaches chg.
    chg       = VALID && (D_IN != D_OUT);
    state_nxt = state;
    hcnt_nxt  = hcnt;
    case (state)
      IDLE: begin
        if (chg) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!chg) begin
          if (HOLD_CYCLES > 0) begin
            state_nxt = HOLD;
            hcnt_nxt  = HOLD_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        // A change arriving on the expiry edge still wins and re-activates.
        if (chg) begin
          state_nxt = ACTIVE;
          hcnt_nxt  = '0;
        end else if (hcnt == '0) begin
          state_nxt = IDLE;
        end else begin
          hcnt_nxt = hcnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        hcnt_nxt  = '0;
      end
    endcase
    en_nxt   = (state_nxt != IDLE) || FORCE_EN;
    gate_inc = VALID && !chg && !en_nxt;
  end

  // FSM state and hold counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // Shadow/forwarded data, registered enable and saturating gated-sample count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      D_OUT     <= '0;
      EN        <= 1'b0;
      GATED_CNT <= '0;
    end else begin
      if (chg) D_OUT <= D_IN;
      EN <= en_nxt;
      if (gate_inc && (GATED_CNT != '1)) GATED_CNT <= GATED_CNT + 1'b1;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_dd_clk_gate_ctrl.sv
// Directed bench for dd_clk_gate_ctrl with a model of the downstream gated register.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_dd_clk_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_in;
  logic       valid;
  logic       force_en;
  logic [3:0] d_out;
  logic       en;
  logic [1:0] state;
  logic [3:0] gated_cnt;
  logic [3:0] dreg;

  int compared = 0;
  int failed   = 0;

  dd_clk_gate_ctrl #(
    .WIDTH(4),
    .HOLD_CYCLES(2),
    .CNT_W(4)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .D_IN(d_in),
    .VALID(valid),
    .FORCE_EN(force_en),
    .D_OUT(d_out),
    .EN(en),
    .STATE(state),
    .GATED_CNT(gated_cnt)
  );

  always #5 clk = ~clk;

  // Downstream enable-gated register fed by D_OUT/EN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dreg <= '0;
    else if (en) dreg <= d_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; d_in = 4'd0; valid = 1'b0; force_en = 1'b0;
    #12;
    chk("rst_dout", 32'(d_out), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(gated_cnt), 32'd0);
    rst = 1'b0;

    // 1: async reset while ACTIVE
    valid = 1'b1; d_in = 4'd5;
    step();
    chk("t1_pre_state", 32'(state), 32'd1);
    chk("t1_pre_dout", 32'(d_out), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("t1_dout", 32'(d_out), 32'd0);
    chk("t1_en", 32'(en), 32'd0);
    chk("t1_state", 32'(state), 32'd0);
    chk("t1_cnt", 32'(gated_cnt), 32'd0);
    rst = 1'b0;

    // 2: first change from reset
    valid = 1'b1; d_in = 4'd1;
    step();
    chk("t2_dout", 32'(d_out), 32'd1);
    chk("t2_en", 32'(en), 32'd1);
    chk("t2_state", 32'(state), 32'd1);

    // 3: repeats -> HOLD for two edges, then IDLE with gated samples
    step();
    chk("t3_dreg", 32'(dreg), 32'd1);
    chk("t3_en0", 32'(en), 32'd1);
    chk("t3_st0", 32'(state), 32'd2);
    step();
    chk("t3_en1", 32'(en), 32'd1);
    chk("t3_st1", 32'(state), 32'd2);
    step();
    chk("t3_en2", 32'(en), 32'd0);
    chk("t3_st2", 32'(state), 32'd0);
    step();
    chk("t3_en3", 32'(en), 32'd0);
    chk("t3_st3", 32'(state), 32'd0);
    chk("t3_cnt", 32'(gated_cnt), 32'd2);

    // 4: change while in HOLD, then VALID=0 with X data drains to IDLE
    d_in = 4'd2;
    step();
    chk("t4_act", 32'(state), 32'd1);
    step();
    chk("t4_hold", 32'(state), 32'd2);
    d_in = 4'd13;
    step();
    chk("t4_dout", 32'(d_out), 32'd13);
    chk("t4_en", 32'(en), 32'd1);
    chk("t4_state", 32'(state), 32'd1);
    valid = 1'b0; d_in = 4'bxxxx;
    step();
    chk("t4_h1_state", 32'(state), 32'd2);
    chk("t4_h1_en", 32'(en), 32'd1);
    step();
    chk("t4_h2_state", 32'(state), 32'd2);
    step();
    chk("t4_idle_state", 32'(state), 32'd0);
    chk("t4_idle_en", 32'(en), 32'd0);
    chk("t4_x_dout", 32'(d_out), 32'd13);
    chk("t4_x_cnt", 32'(gated_cnt), 32'd2);

    // 5: FORCE_EN in IDLE with a repeated sample
    valid = 1'b1; d_in = 4'd13; force_en = 1'b1;
    step();
    chk("t5_en", 32'(en), 32'd1);
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_cnt", 32'(gated_cnt), 32'd2);
    force_en = 1'b0; valid = 1'b0;
    step();
    chk("t5_en_drop", 32'(en), 32'd0);

    // 6: counter saturation, then a change
    valid = 1'b1; d_in = 4'd13;
    for (int i = 0; i < 20; i++) step();
    chk("t6_sat", 32'(gated_cnt), 32'd15);
    chk("t6_idle", 32'(state), 32'd0);
    d_in = 4'd15;
    step();
    chk("t6_dout", 32'(d_out), 32'd15);
    chk("t6_en", 32'(en), 32'd1);
    chk("t6_state", 32'(state), 32'd1);
    chk("t6_cnt", 32'(gated_cnt), 32'd15);
    valid = 1'b0;
    step();
    chk("t6_dreg", 32'(dreg), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
